// File: rtl/luma_pkg.sv
// Shared widths, divider state encoding and threshold clamp for the luma mask path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: Y_W/SUM_W/CNT_W/H_W/V_W width constants, div_state_t, clamp_thresh().
package luma_pkg;

    localparam int Y_W    = 10;
    localparam int SUM_W  = 30;
    localparam int CNT_W  = 21;
    localparam int H_W    = 11;
    localparam int V_W    = 10;
    localparam int ITER_W = 5;

    localparam logic [Y_W-1:0] Y_MAX      = 10'd1023;
    localparam logic [Y_W-1:0] THRESH_RST = 10'd512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // quotient + signed offset, clamped to [0, 1023]. The sum is formed in
    // 12 bits: with quotient <= 1023 and offset in [-1024, 1023] the true
    // result lies in [-1024, 2046], so bit 11 is the sign and bit 10 flags
    // an overflow past 1023 when non-negative.
    function automatic logic [Y_W-1:0] clamp_thresh(input logic [Y_W-1:0] q,
                                                    input logic [10:0]    off);
        logic [11:0] t;
        t = {2'b00, q} + {off[10], off};
        if (t[11]) begin
            clamp_thresh = '0;
        end else if (t[10]) begin
            clamp_thresh = Y_MAX;
        end else begin
            clamp_thresh = t[Y_W-1:0];
        end
    endfunction

endpackage

// File: rtl/luma_divider.sv
// Serial restoring unsigned divider, 30-bit dividend by 21-bit divisor, quotient saturated to 10 bits.
// Latency: start -> done is 31 cycles (30 DIV + DONE); a zero divisor goes straight to DONE (quotient 0).
// Backpressure: none; start_in is only honoured while idle, the caller must check busy_out.
//
// Ports: clk_in/rst_in (async active-low), start_in + dividend_in/divisor_in operands,
//        busy_out (any non-IDLE state), done_out (one cycle, quotient_out valid).
module luma_divider
    import luma_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [SUM_W-1:0] dividend_in,
    input  logic [CNT_W-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [Y_W-1:0]   quotient_out
);

    div_state_t        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SUM_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  dsr_q, dsr_d;

    // Partial remainder with the next dividend bit shifted in. The remainder
    // is always below the divisor, so one extra bit is enough headroom.
    logic [CNT_W:0] rem_shift;
    assign rem_shift = {rem_q, quo_q[SUM_W-1]};

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    dsr_d  = divisor_in;
                    rem_d  = '0;
                    iter_d = '0;
                    if (divisor_in == '0) begin
                        quo_d   = '0;
                        state_d = DONE;
                    end else begin
                        quo_d   = dividend_in;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // quo_q doubles as the dividend shift register: the dividend
                // leaves at the top while quotient bits enter at the bottom.
                if (rem_shift >= {1'b0, dsr_q}) begin
                    rem_d = CNT_W'(rem_shift - {1'b0, dsr_q});
                    quo_d = {quo_q[SUM_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[CNT_W-1:0];
                    quo_d = {quo_q[SUM_W-2:0], 1'b0};
                end
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(SUM_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            iter_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
        end
    end

    assign busy_out     = (state_q != IDLE);
    assign done_out     = (state_q == DONE);
    assign quotient_out = (|quo_q[SUM_W-1:Y_W]) ? Y_MAX : quo_q[Y_W-1:0];

endmodule

// File: rtl/luma_adaptive_threshold.sv
// Per-pixel luminance mask against a threshold derived from the previous frame's mean Y.
// Latency: valid_in -> valid_out/mask_out is Y_LATENCY+1 cycles; frame mean 32 cycles after the frame-end pixel.
// Backpressure: none, one pixel per cycle; a frame end while the divider is busy drops that mean and sets drop_out.
//
// Ports: clk_in, rst_in (async active-low); valid_in/hcount_in/vcount_in at converter input,
//        y_in Y_LATENCY cycles later; valid_out/hcount_out/vcount_out/mask_out aligned result;
//        thresh_out, mean_out, mean_valid_out (pulse), drop_out (sticky).
// Optional: LUMA_MINMAX_EN adds ymin_out/ymax_out, the per-frame min/max of Y latched at frame end.
module luma_adaptive_threshold
    import luma_pkg::*;
#(
    parameter int                 H_ACTIVE  = 1280,
    parameter int                 V_ACTIVE  = 720,
    parameter int                 Y_LATENCY = 3,
    parameter logic signed [10:0] OFFSET    = 11'sd0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [9:0]  y_in,
    output logic        valid_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        mask_out,
    output logic [9:0]  thresh_out,
    output logic [9:0]  mean_out,
    output logic        mean_valid_out,
    output logic        drop_out
`ifdef LUMA_MINMAX_EN
    ,
    output logic [9:0]  ymin_out,
    output logic [9:0]  ymax_out
`endif
);

    // ---------------------------------------------------------------
    // Delay line: re-align coordinates with the converter's Y output
    // ---------------------------------------------------------------
    logic           dl_valid_q [Y_LATENCY];
    logic           dl_valid_d [Y_LATENCY];
    logic [H_W-1:0] dl_h_q     [Y_LATENCY];
    logic [H_W-1:0] dl_h_d     [Y_LATENCY];
    logic [V_W-1:0] dl_v_q     [Y_LATENCY];
    logic [V_W-1:0] dl_v_d     [Y_LATENCY];

    always_comb begin
        dl_valid_d[0] = valid_in;
        dl_h_d[0]     = hcount_in;
        dl_v_d[0]     = vcount_in;
        for (int i = 1; i < Y_LATENCY; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_h_d[i]     = dl_h_q[i-1];
            dl_v_d[i]     = dl_v_q[i-1];
        end
    end

    logic           a_valid;
    logic [H_W-1:0] a_h;
    logic [V_W-1:0] a_v;
    logic           frame_end;

    assign a_valid   = dl_valid_q[Y_LATENCY-1];
    assign a_h       = dl_h_q[Y_LATENCY-1];
    assign a_v       = dl_v_q[Y_LATENCY-1];
    assign frame_end = a_valid && (a_h == H_W'(H_ACTIVE - 1)) && (a_v == V_W'(V_ACTIVE - 1));

    // ---------------------------------------------------------------
    // Divider
    // ---------------------------------------------------------------
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [Y_W-1:0]   div_quot;
    logic [SUM_W-1:0] sum_acc;
    logic [CNT_W-1:0] cnt_acc;

    luma_divider u_div (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (div_start),
        .dividend_in  (sum_acc),
        .divisor_in   (cnt_acc),
        .busy_out     (div_busy),
        .done_out     (div_done),
        .quotient_out (div_quot)
    );

    // ---------------------------------------------------------------
    // Accumulators, mask, threshold
    // ---------------------------------------------------------------
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_out_q, valid_out_d;
    logic [H_W-1:0]   hcount_q, hcount_d;
    logic [V_W-1:0]   vcount_q, vcount_d;
    logic             mask_q, mask_d;
    logic [Y_W-1:0]   thresh_q, thresh_d;
    logic [Y_W-1:0]   mean_q, mean_d;
    logic             mean_valid_q, mean_valid_d;
    logic             drop_q, drop_d;

    // Running totals including the current pixel; the frame-end pixel is
    // handed to the divider through these so it is part of its own frame.
    assign sum_acc = a_valid ? (sum_q + SUM_W'(y_in)) : sum_q;
    assign cnt_acc = a_valid ? (cnt_q + CNT_W'(1))    : cnt_q;

    always_comb begin
        sum_d        = sum_acc;
        cnt_d        = cnt_acc;
        valid_out_d  = a_valid;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        mask_d       = mask_q;
        thresh_d     = thresh_q;
        mean_d       = mean_q;
        mean_valid_d = 1'b0;
        drop_d       = drop_q;
        div_start    = 1'b0;

        if (a_valid) begin
            mask_d   = (y_in > thresh_q);
            hcount_d = a_h;
            vcount_d = a_v;
        end

        // busy includes DONE, so a frame end coinciding with DONE drops.
        if (frame_end) begin
            sum_d = '0;
            cnt_d = '0;
            if (div_busy) begin
                drop_d = 1'b1;
            end else begin
                div_start = 1'b1;
            end
        end

        if (div_done) begin
            mean_d       = div_quot;
            mean_valid_d = 1'b1;
            thresh_d     = clamp_thresh(div_quot, OFFSET);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < Y_LATENCY; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_h_q[i]     <= '0;
                dl_v_q[i]     <= '0;
            end
            sum_q        <= '0;
            cnt_q        <= '0;
            valid_out_q  <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            mask_q       <= 1'b0;
            thresh_q     <= THRESH_RST;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            for (int i = 0; i < Y_LATENCY; i++) begin
                dl_valid_q[i] <= dl_valid_d[i];
                dl_h_q[i]     <= dl_h_d[i];
                dl_v_q[i]     <= dl_v_d[i];
            end
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            valid_out_q  <= valid_out_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            mask_q       <= mask_d;
            thresh_q     <= thresh_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
            drop_q       <= drop_d;
        end
    end

    assign valid_out      = valid_out_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign mask_out       = mask_q;
    assign thresh_out     = thresh_q;
    assign mean_out       = mean_q;
    assign mean_valid_out = mean_valid_q;
    assign drop_out       = drop_q;

`ifdef LUMA_MINMAX_EN
    // ---------------------------------------------------------------
    // Per-frame Y extremes; running registers restart at frame end
    // ---------------------------------------------------------------
    logic [Y_W-1:0] ymin_run_q, ymin_run_d;
    logic [Y_W-1:0] ymax_run_q, ymax_run_d;
    logic [Y_W-1:0] ymin_q, ymin_d;
    logic [Y_W-1:0] ymax_q, ymax_d;
    logic [Y_W-1:0] cur_min;
    logic [Y_W-1:0] cur_max;

    always_comb begin
        cur_min    = (a_valid && (y_in < ymin_run_q)) ? y_in : ymin_run_q;
        cur_max    = (a_valid && (y_in > ymax_run_q)) ? y_in : ymax_run_q;
        ymin_run_d = cur_min;
        ymax_run_d = cur_max;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        if (frame_end) begin
            ymin_d     = cur_min;
            ymax_d     = cur_max;
            ymin_run_d = Y_MAX;
            ymax_run_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ymin_run_q <= Y_MAX;
            ymax_run_q <= '0;
            ymin_q     <= Y_MAX;
            ymax_q     <= '0;
        end else begin
            ymin_run_q <= ymin_run_d;
            ymax_run_q <= ymax_run_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
        end
    end

    assign ymin_out = ymin_q;
    assign ymax_out = ymax_q;
`endif

endmodule

// File: tb/tb_luma_adaptive_threshold.sv
// Self-checking bench for luma_adaptive_threshold: three instances (OFFSET 0, -300, +1000) share one stimulus.
// Latency: models the converter's 3-cycle Y delay; mask results checked through an expected-value queue.
// Backpressure: n/a.
module tb_luma_adaptive_threshold;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int LAT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic [9:0]  y_in = '0;

    logic        vo  [3];
    logic [10:0] ho  [3];
    logic [9:0]  vco [3];
    logic        mk  [3];
    logic [9:0]  th  [3];
    logic [9:0]  mn  [3];
    logic        mv  [3];
    logic        dr  [3];
`ifdef LUMA_MINMAX_EN
    logic [9:0]  ymn [3];
    logic [9:0]  ymx [3];
`endif

    always #5 clk_in = ~clk_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        luma_adaptive_threshold #(
            .H_ACTIVE  (H),
            .V_ACTIVE  (V),
            .Y_LATENCY (LAT),
            .OFFSET    (gi == 0 ? 11'sd0 : (gi == 1 ? -11'sd300 : 11'sd1000))
        ) u_dut (
            .clk_in         (clk_in),
            .rst_in         (rst_in),
            .valid_in       (valid_in),
            .hcount_in      (hcount_in),
            .vcount_in      (vcount_in),
            .y_in           (y_in),
            .valid_out      (vo[gi]),
            .hcount_out     (ho[gi]),
            .vcount_out     (vco[gi]),
            .mask_out       (mk[gi]),
            .thresh_out     (th[gi]),
            .mean_out       (mn[gi]),
            .mean_valid_out (mv[gi]),
            .drop_out       (dr[gi])
`ifdef LUMA_MINMAX_EN
            ,
            .ymin_out       (ymn[gi]),
            .ymax_out       (ymx[gi])
`endif
        );
    end

    typedef struct {
        logic [9:0] y;
        logic       exp_mask;
    } vec_t;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        m;
    } exp_t;

    vec_t       tbl [56];
    exp_t       sbq [$];
    logic [9:0] ypipe [4];

    int n_chk    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int vo_cyc   = -1;
    int mv_cyc   = -1;
    int mv_cnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame f: eight Y values (first pixel in the MSBs) and their expected masks.
    task automatic ld_frame(input int f, input logic [79:0] ys, input logic [7:0] ms);
        for (int i = 0; i < 8; i++) begin
            tbl[f*8+i].y        = ys[79-10*i -: 10];
            tbl[f*8+i].exp_mask = ms[7-i];
        end
    endtask

    // One cycle: drive inputs at the falling edge, present the Y the modelled
    // converter produced LAT cycles earlier, and check any aligned output.
    task automatic tick(input logic v, input int h, input int vc, input int y);
        exp_t e;
        @(negedge clk_in);
        cyc++;
        for (int k = 3; k > 0; k--) ypipe[k] = ypipe[k-1];
        ypipe[0]  = y[9:0];
        valid_in  = v;
        hcount_in = h[10:0];
        vcount_in = vc[9:0];
        y_in      = ypipe[LAT];
        if (vo[0]) begin
            if (vo_cyc < 0) vo_cyc = cyc;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_hcount", int'(ho[0]),  int'(e.h));
                chk("sb_vcount", int'(vco[0]), int'(e.v));
                chk("sb_mask",   int'(mk[0]),  int'(e.m));
            end
        end
        if (mv[0]) begin
            mv_cnt++;
            mv_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0);
    endtask

    task automatic run_frame(input int f, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.h = 11'(i % H);
            e.v = 10'(i / H);
            e.m = tbl[f*8+i].exp_mask;
            sbq.push_back(e);
            tick(1'b1, i % H, i / H, int'(tbl[f*8+i].y));
            last_cyc = cyc;
            if (gaps && (i % 2 == 1) && (i != 7)) tick(1'b0, 0, 0, 0);
        end
    endtask

    task automatic wait_mean(input string tag, input int exp_mean,
                             input int t0, input int t1, input int t2);
        idle(45);
        chk({tag, "_mean_valid_count"}, mv_cnt, 1);
        chk({tag, "_mean_latency"}, mv_cyc - last_cyc, LAT + 32);
        chk({tag, "_mean"}, int'(mn[0]), exp_mean);
        chk({tag, "_thresh_off0"}, int'(th[0]), t0);
        chk({tag, "_thresh_offm300"}, int'(th[1]), t1);
        chk({tag, "_thresh_offp1000"}, int'(th[2]), t2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid_out"}, int'(vo[0]), 0);
        chk({tag, "_mask_out"}, int'(mk[0]), 0);
        chk({tag, "_hcount_out"}, int'(ho[0]), 0);
        chk({tag, "_vcount_out"}, int'(vco[0]), 0);
        chk({tag, "_mean_out"}, int'(mn[0]), 0);
        chk({tag, "_mean_valid"}, int'(mv[0]), 0);
        chk({tag, "_drop_out"}, int'(dr[0]), 0);
        for (int d = 0; d < 3; d++) chk({tag, "_thresh_out"}, int'(th[d]), 512);
`ifdef LUMA_MINMAX_EN
        chk({tag, "_ymin_out"}, int'(ymn[0]), 1023);
        chk({tag, "_ymax_out"}, int'(ymx[0]), 0);
`endif
    endtask

    initial begin
        int t_single;
        int t_d;

        for (int k = 0; k < 4; k++) ypipe[k] = '0;
        ld_frame(0, {8{10'd200}}, 8'b0000_0000);
        ld_frame(1, {10'd201, 10'd200, 10'd199, 10'd0, 10'd50, 10'd100, 10'd40, 10'd10}, 8'b1000_0000);
        ld_frame(2, {{4{10'd1023}}, {4{10'd777}}}, 8'b1111_1111);
        ld_frame(3, {8{10'd300}}, 8'b0000_0000);
        ld_frame(4, {8{10'd500}}, 8'b0000_0000);
        ld_frame(5, {8{10'd400}}, 8'b1111_1111);
        ld_frame(6, {10'd5, 10'd900, 10'd17, 10'd300, 10'd600, 10'd513, 10'd512, 10'd100}, 8'b0100_1100);

        #2 rst_in = 1'b0;
        idle(3);
        rst_in = 1'b1;
        idle(2);
        check_reset("por");

        // Single pixel above the reset threshold.
        begin
            exp_t e;
            e.h = 11'd0; e.v = 10'd0; e.m = 1'b1;
            sbq.push_back(e);
        end
        vo_cyc = -1;
        tick(1'b1, 0, 0, 600);
        t_single = cyc;
        idle(6);
        chk("single_latency", vo_cyc - t_single, LAT + 1);
        chk("single_thresh", int'(th[0]), 512);

        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        idle(1);

        // Flat frame, then a mixed frame with gaps around the new threshold.
        mv_cnt = 0;
        run_frame(0, 1'b0);
        wait_mean("frameA", 200, 200, 0, 1023);

        mv_cnt = 0;
        run_frame(1, 1'b1);
        wait_mean("frameB", 100, 100, 0, 1023);

        mv_cnt = 0;
        run_frame(2, 1'b0);
        wait_mean("frameC", 900, 900, 600, 1023);

        // Back-to-back frames: the second frame end lands while dividing.
        mv_cnt = 0;
        run_frame(3, 1'b0);
        t_d = last_cyc;
        run_frame(4, 1'b0);
        last_cyc = t_d;
        wait_mean("frameDE", 300, 300, 0, 1023);
        chk("drop_sticky", int'(dr[0]), 1);

        // Reset ten cycles into the division.
        mv_cnt = 0;
        run_frame(5, 1'b0);
        idle(LAT + 11);
        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        check_reset("middiv");
        idle(40);
        chk("middiv_no_mean_pulse", mv_cnt, 0);

        mv_cnt = 0;
        run_frame(6, 1'b0);
        wait_mean("frameH", 368, 368, 68, 1023);
`ifdef LUMA_MINMAX_EN
        chk("frameH_ymin", int'(ymn[0]), 5);
        chk("frameH_ymax", int'(ymx[0]), 900);
`endif

        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
